// File: rtl/prog_timer_if.sv
//------------------------------------------------------------------------------
// Module   : prog_timer_if
// Brief    : Control/status bundle between a bit sequencer and prog_timer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface prog_timer_if #(
  parameter int WID = 20,
  parameter int TCW = 4
);
  logic           start;
  logic           stop;
  logic           clrTimer;
  logic           mode;
  logic [WID-1:0] period;
  logic [WID-1:0] count;
  logic           busy;
  logic           tick;
  logic           half_tick;
  logic           timerDone;
  logic [TCW-1:0] tick_cnt;

  modport master (
    output start, stop, clrTimer, mode, period,
    input  count, busy, tick, half_tick, timerDone, tick_cnt
  );

  modport slave (
    input  start, stop, clrTimer, mode, period,
    output count, busy, tick, half_tick, timerDone, tick_cnt
  );
endinterface

`default_nettype wire

// File: rtl/prog_timer.sv
//------------------------------------------------------------------------------
// Module   : prog_timer
// Brief    : Run-time loaded interval timer with end/mid-period ticks,
//            one-shot or periodic mode and a wrapping tick counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_timer #(
  parameter int WID = 20,
  parameter int TCW = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  prog_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WID-1:0] c_one    = {{(WID-1){1'b0}}, 1'b1};
  localparam logic [TCW-1:0] c_tc_one = {{(TCW-1){1'b0}}, 1'b1};

  state_t         r_state,    w_state_d;
  logic [WID-1:0] r_count,    w_count_d;
  logic [WID-1:0] r_pq,       w_pq_d;
  logic           r_mode,     w_mode_d;
  logic [TCW-1:0] r_tick_cnt, w_tcnt_d;

  logic           w_last;
  logic           w_tick;
  logic           w_half;
  logic [WID-1:0] w_period_eff;

  // P_q >= 1 always, so P_q-1 cannot underflow.
  assign w_last       = (r_count == (r_pq - c_one));
  assign w_tick       = (r_state == S_RUN) && w_last;
  assign w_half       = (r_state == S_RUN) && (r_count == (r_pq >> 1));
  assign w_period_eff = (bus.period == '0) ? c_one : bus.period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_pq       <= c_one;
      r_mode     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_pq       <= w_pq_d;
      r_mode     <= w_mode_d;
      r_tick_cnt <= w_tcnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_pq_d    = r_pq;
    w_mode_d  = r_mode;
    w_tcnt_d  = r_tick_cnt;

    // start clears and stop freezes the tick counter, even in a tick cycle.
    if (w_tick && !bus.start && !bus.stop)
      w_tcnt_d = r_tick_cnt + c_tc_one;

    if (bus.stop) begin
      w_state_d = S_IDLE;
      w_count_d = '0;
    end else if (bus.start) begin
      w_state_d = S_RUN;
      w_count_d = '0;
      w_tcnt_d  = '0;
      w_pq_d    = w_period_eff;
      w_mode_d  = bus.mode;
    end else begin
      case (r_state)
        S_IDLE: w_count_d = '0;
        S_RUN: begin
          if (bus.clrTimer) begin
            w_count_d = '0;
          end else if (w_last) begin
            if (r_mode) w_count_d = '0;
            else        w_state_d = S_DONE;
          end else begin
            w_count_d = r_count + c_one;
          end
        end
        S_DONE: ;
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  assign bus.count     = r_count;
  assign bus.busy      = (r_state == S_RUN);
  assign bus.tick      = w_tick;
  assign bus.half_tick = w_half;
  assign bus.timerDone = (r_state == S_DONE);
  assign bus.tick_cnt  = r_tick_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prog_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_prog_timer
// Brief    : Scoreboard bench for prog_timer against an elapsed-time model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_timer_if #(.WID(20), .TCW(4)) bus ();

  prog_timer #(.WID(20), .TCW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] count;
    logic        busy;
    logic        tick;
    logic        half;
    logic        done;
    logic [3:0]  tcnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  // Model: status 0 idle / 1 run / 2 done; count derives from cycles since t0.
  int m_status = 0;
  int m_t0     = 0;
  int m_p      = 1;
  bit m_per    = 1'b0;
  int m_ticks  = 0;
  int cyc      = 0;

  function automatic exp_t model_out();
    exp_t x;
    int   e, ph;
    x = '0;
    e = cyc - m_t0;
    if (m_status == 1) begin
      ph      = m_per ? (e % m_p) : e;
      x.count = 20'(ph);
      x.busy  = 1'b1;
      x.tick  = (ph == m_p - 1);
      x.half  = (ph == m_p / 2);
    end else if (m_status == 2) begin
      x.count = 20'(m_p - 1);
      x.done  = 1'b1;
    end
    x.tcnt = 4'(m_ticks % 16);
    return x;
  endfunction

  task automatic step(input bit st, input bit sp, input bit cl, input bit md,
                      input logic [19:0] per, input bit r);
    exp_t x;
    @(negedge clk);
    rst = r;
    if (r) begin
      m_status = 0; m_p = 1; m_per = 1'b0; m_ticks = 0;
    end
    x = model_out();
    q.push_back(x);
    bus.start    = st;
    bus.stop     = sp;
    bus.clrTimer = cl;
    bus.mode     = md;
    bus.period   = per;
    if (!r) begin
      if (x.tick && !st && !sp) m_ticks++;
      if (sp) begin
        m_status = 0;
      end else if (st) begin
        m_status = 1;
        m_p      = (per == 20'd0) ? 1 : int'(per);
        m_per    = md;
        m_t0     = cyc + 1;
        m_ticks  = 0;
      end else if (m_status == 1) begin
        if (cl) m_t0 = cyc + 1;
        else if (x.tick && !m_per) m_status = 2;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 1'($urandom), 20'($urandom_range(0, 63)), 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [19:0] rand_period();
    case ($urandom_range(0, 4))
      0:       return 20'($urandom_range(0, 1));
      1:       return 20'($urandom_range(2, 6));
      2:       return 20'($urandom_range(7, 20));
      3:       return 20'($urandom_range(0, 63));
      default: return 20'($urandom);
    endcase
  endfunction

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        if (!stim_done) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty at cycle %0d: got 0 entries expected 1", cyc);
        end
      end else begin
        e = q.pop_front();
        chk("count",     int'(bus.count),     int'(e.count));
        chk("busy",      int'(bus.busy),      int'(e.busy));
        chk("tick",      int'(bus.tick),      int'(e.tick));
        chk("half_tick", int'(bus.half_tick), int'(e.half));
        chk("timerDone", int'(bus.timerDone), int'(e.done));
        chk("tick_cnt",  int'(bus.tick_cnt),  int'(e.tcnt));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clrTimer = 1'b0;
    bus.mode  = 1'b0; bus.period = '0;

    step(0, 0, 0, 0, 20'd0, 1);
    step(0, 0, 0, 0, 20'd0, 1);
    step(0, 0, 0, 0, 20'd0, 0);
    idle(2);

    // Periodic 10, long enough for several ticks; period input jitters.
    step(1, 0, 0, 1, 20'd10, 0);
    idle(45);

    // clrTimer at count 7, then watch the next full period.
    step(1, 0, 0, 1, 20'd10, 0);
    idle(7);
    step(0, 0, 1, 1, 20'd3, 0);
    idle(14);

    // Restart in RUN: 20 -> 8.
    step(1, 0, 0, 1, 20'd20, 0);
    idle(12);
    step(1, 0, 0, 1, 20'd8, 0);
    idle(20);

    // Period 1 periodic long enough to wrap tick_cnt.
    step(1, 0, 0, 1, 20'd1, 0);
    idle(20);
    // Period 0 and 1 one-shot.
    step(1, 0, 0, 0, 20'd0, 0);
    idle(4);
    step(1, 0, 0, 0, 20'd1, 0);
    idle(4);

    // One-shot 4, then a second start clears timerDone.
    step(1, 0, 0, 0, 20'd4, 0);
    idle(8);
    step(1, 0, 0, 0, 20'd4, 0);
    idle(3);
    step(0, 1, 0, 0, 20'd4, 0);
    idle(2);

    // stop together with start.
    step(1, 0, 0, 1, 20'd10, 0);
    idle(3);
    step(1, 1, 0, 1, 20'd10, 0);
    idle(3);

    // Asynchronous reset at count 3 of a periodic-5 run.
    step(1, 0, 0, 1, 20'd5, 0);
    idle(3);
    step(0, 0, 0, 1, 20'd5, 1);
    step(0, 0, 0, 1, 20'd5, 1);
    idle(12);

    // Large period never ticks before the stop.
    step(1, 0, 0, 1, 20'hFFFFF, 0);
    idle(5);
    step(0, 1, 0, 0, 20'd0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0)
        step(0, 0, 0, 0, 20'd0, 1);
      else
        step($urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 24) == 0, 1'($urandom), rand_period(), 1'b0);
    end

    stim_done = 1'b1;
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
